// File: rtl/fb_pixel_packer_pkg.sv
`default_nettype none
// fb_pixel_packer_pkg: shared constants, word type and FSM states for the
// framebuffer pixel packer.
package fb_pixel_packer_pkg;

   localparam int PIX_PER_WORD   = 16;
   localparam int FB_WIDTH       = 160;
   localparam int FB_HEIGHT      = 144;
   localparam int FB_ADDR_W      = 11;
   localparam int WORDS_PER_LINE = FB_WIDTH / PIX_PER_WORD;
   localparam int FRAME_WORDS    = WORDS_PER_LINE * FB_HEIGHT;

   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic [31:0]          data;
   } fb_word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } pk_state_t;

   function automatic int words_per_line(input int width);
      return width / PIX_PER_WORD;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fb_pixel_packer_fifo.sv
`default_nettype none
// fb_pixel_packer_fifo: synchronous FIFO of packed address/data words with
// occupancy count. DEPTH must be a power of two so the pointers wrap freely.
module fb_pixel_packer_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 43
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [W-1:0]               data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_q] <= data_i;
      end
   end

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push_i) begin
         wr_d = wr_q + AW'(1);
      end
      if (pop_i) begin
         rd_d = rd_q + AW'(1);
      end
      if (push_i && !pop_i) begin
         count_d = count_q + CW'(1);
      end else if (!push_i && pop_i) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fb_pixel_packer.sv
`default_nettype none
// fb_pixel_packer: packs the raster-order 2bpp pixel stream into 32-bit words
// (pixel 0 in the MSBs) and writes them to the VRAM port through a word FIFO.
module fb_pixel_packer
   import fb_pixel_packer_pkg::*;
#(
   parameter int WIDTH      = FB_WIDTH,
   parameter int HEIGHT     = FB_HEIGHT,
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int BASE_ADDR  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_valid_i,
   input  logic              pix_sof_i,
   input  logic [1:0]        pix_data_i,
   output logic              pix_ready_o,
   output logic              fb_we_o,
   output logic [ADDR_W-1:0] fb_addr_o,
   output logic [31:0]       fb_data_o,
   input  logic              fb_ready_i,
   output logic              frame_done_o,
   output logic              err_sof_o
);
   localparam int WPL = words_per_line(WIDTH);
   localparam int XW  = $clog2(WIDTH);
   localparam int YW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int DW  = ADDR_W + 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } word_t;

   pk_state_t         state_q, state_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [ADDR_W-1:0] lb_q, lb_d;
   logic [29:0]       sr_q, sr_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;

   logic              pix_fire;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   word_t             push_word, head_word;

   fb_pixel_packer_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (DW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .data_i  (push_word),
      .pop_i   (fifo_pop),
      .data_o  (head_word),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      lb_d         = lb_q;
      sr_d         = sr_q;
      err_d        = err_q;
      fifo_push    = 1'b0;
      pix_ready_o  = 1'b0;
      frame_done_o = 1'b0;
      // The 15 earlier pixels of the word sit in sr_q; the current pixel lands in [1:0].
      push_word.addr = ADDR_W'(BASE_ADDR) + lb_q + ADDR_W'(x_q >> 4);
      push_word.data = {sr_q, pix_data_i};

      case (state_q)
         IDLE:    pix_ready_o = 1'b1;
         ACTIVE:  pix_ready_o = !fifo_full;
         DRAIN: begin
            if (fifo_count == '0 && !we_q) begin
               frame_done_o = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      pix_fire = pix_valid_i & pix_ready_o;

      if (pix_fire && pix_sof_i) begin
         if (state_q == ACTIVE) begin
            err_d = 1'b1;
         end
         state_d = ACTIVE;
         sr_d    = {28'd0, pix_data_i};
         x_d     = XW'(1);
         y_d     = '0;
         lb_d    = '0;
      end else if (pix_fire && state_q == ACTIVE) begin
         sr_d      = {sr_q[27:0], pix_data_i};
         fifo_push = (x_q[3:0] == 4'hF);
         if (x_q == XW'(WIDTH - 1)) begin
            x_d  = '0;
            y_d  = y_q + YW'(1);
            lb_d = lb_q + ADDR_W'(WPL);
            if (y_q == YW'(HEIGHT - 1)) begin
               state_d = DRAIN;
            end
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   // Output stage reloads only when empty or its current word is being accepted.
   always_comb begin
      fifo_pop = !fifo_empty && (!we_q || fb_ready_i);
      we_d     = we_q;
      addr_d   = addr_q;
      data_d   = data_q;
      if (fifo_pop) begin
         we_d   = 1'b1;
         addr_d = head_word.addr;
         data_d = head_word.data;
      end else if (fb_ready_i) begin
         we_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         lb_q    <= '0;
         sr_q    <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         lb_q    <= lb_d;
         sr_q    <= sr_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign fb_we_o   = we_q;
   assign fb_addr_o = addr_q;
   assign fb_data_o = data_q;
   assign err_sof_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_packer.sv
`default_nettype none
// tb_fb_pixel_packer: directed and randomized checks of the pixel packer
// against a frame-level reference model (pixel index -> word index / data).
module tb_fb_pixel_packer;
   import fb_pixel_packer_pkg::*;

   localparam int W      = FB_WIDTH;
   localparam int H      = 12;
   localparam int NPIX   = W * H;
   localparam int NWORDS = WORDS_PER_LINE * H;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pix_valid, pix_sof;
   logic [1:0]  pix_data;
   logic        pix_ready;
   logic        fb_we;
   logic [FB_ADDR_W-1:0] fb_addr;
   logic [31:0] fb_data;
   logic        fb_ready;
   logic        frame_done, err_sof;

   int total = 0;
   int bad   = 0;
   int n_writes = 0;
   int n_done   = 0;
   int m_frames = 0;
   bit stall = 0, rnd_valid = 0, rnd_ready = 0;

   fb_word_t exp_q[$];
   bit       m_in = 0, m_err = 0;
   int       m_p = 0;
   logic [1:0] m_buf [16];
   logic     prev_we = 0, prev_rdy = 0, prev_wx = 0;
   logic [FB_ADDR_W-1:0] prev_addr = '0;
   logic [31:0] prev_data = '0;

   always #5 clk = ~clk;

   fb_pixel_packer #(
      .WIDTH      (W),
      .HEIGHT     (H),
      .FIFO_DEPTH (2),
      .ADDR_W     (FB_ADDR_W),
      .BASE_ADDR  (0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pix_valid_i  (pix_valid),
      .pix_sof_i    (pix_sof),
      .pix_data_i   (pix_data),
      .pix_ready_o  (pix_ready),
      .fb_we_o      (fb_we),
      .fb_addr_o    (fb_addr),
      .fb_data_o    (fb_data),
      .fb_ready_i   (fb_ready),
      .frame_done_o (frame_done),
      .err_sof_o    (err_sof)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic summary_and_finish();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (stall)          fb_ready = 1'b0;
      else if (rnd_ready) fb_ready = 1'($urandom_range(0, 1));
      else                fb_ready = 1'b1;
   endtask

   task automatic send_pix(input logic sof, input logic [1:0] d);
      int n = 0;
      bit acc = 0;
      while (!acc) begin
         if (rnd_valid && ($urandom_range(0, 1) == 0)) begin
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
         end else begin
            pix_valid = 1'b1;
            pix_sof   = sof;
            pix_data  = d;
         end
         @(negedge clk);
         acc = (pix_valid && pix_ready);
         step();
         n++;
         if (!acc && n > 4000) begin
            total++;
            bad++;
            $display("FAIL send_timeout: observed pix_ready=%0b for %0d cycles, expected acceptance", pix_ready, n);
            summary_and_finish();
         end
      end
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (n_done < target && n < 3000) begin
         step();
         n++;
      end
      chk("frame_done_count", 64'(n_done), 64'(target));
   endtask

   // Reference model: pixel index p in the frame maps to word p/16, slot p%16.
   always @(negedge clk) begin
      fb_word_t w, got;
      logic wx;
      if (!rst_n) begin
         exp_q.delete();
         m_in    = 0;
         m_p     = 0;
         m_err   = 0;
         prev_we = 0;
         prev_rdy = 0;
         prev_wx = 0;
      end else begin
         if (prev_we && !prev_rdy) begin
            chk("stall_hold_we",   64'(fb_we),   64'(1));
            chk("stall_hold_addr", 64'(fb_addr), 64'(prev_addr));
            chk("stall_hold_data", 64'(fb_data), 64'(prev_data));
         end
         if (frame_done) begin
            n_done++;
            chk("done_one_cycle_after_last_write", 64'(prev_wx), 64'(1));
            chk("done_all_words_written", 64'(exp_q.size()), 64'(0));
            chk("done_frame_complete", 64'(m_in), 64'(0));
         end
         wx = fb_we && fb_ready;
         if (wx) begin
            n_writes++;
            total++;
            assert (exp_q.size() > 0) else begin
               bad++;
               $error("FAIL unexpected_write: observed addr=%0h data=%0h, expected no write", fb_addr, fb_data);
            end
            if (exp_q.size() > 0) begin
               got = exp_q.pop_front();
               chk("write_addr", 64'(fb_addr), 64'(got.addr));
               chk("write_data", 64'(fb_data), 64'(got.data));
            end
         end
         if (pix_valid && pix_ready) begin
            if (pix_sof) begin
               if (m_in) m_err = 1;
               m_in = 1;
               m_p  = 0;
            end
            if (m_in) begin
               m_buf[m_p % 16] = pix_data;
               if (m_p % 16 == 15) begin
                  w.addr = FB_ADDR_W'(m_p / 16);
                  w.data = '0;
                  for (int k = 0; k < 16; k++) w.data = {w.data[29:0], m_buf[k]};
                  exp_q.push_back(w);
               end
               m_p++;
               if (m_p == NPIX) begin
                  m_in = 0;
                  m_frames++;
               end
            end
         end
         prev_we   = fb_we;
         prev_rdy  = fb_ready;
         prev_addr = fb_addr;
         prev_data = fb_data;
         prev_wx   = wx;
      end
   end

   initial begin
      int p;
      int wsave;
      rst_n     = 1'b0;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_data  = 2'd0;
      fb_ready  = 1'b1;
      $display("config: full-size frame %0d words, bench frame %0d words", FRAME_WORDS, NWORDS);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pix_ready",  64'(pix_ready),  64'(1));
      chk("reset_fb_we",      64'(fb_we),      64'(0));
      chk("reset_fb_addr",    64'(fb_addr),    64'(0));
      chk("reset_fb_data",    64'(fb_data),    64'(0));
      chk("reset_frame_done", 64'(frame_done), 64'(0));
      chk("reset_err_sof",    64'(err_sof),    64'(0));
      rst_n = 1'b1;

      // Full frame, shade = x mod 4, port always ready.
      for (int i = 0; i < NPIX; i++) send_pix(i == 0, 2'((i % W) % 4));
      wait_done(1);
      chk("frameA_writes", 64'(n_writes), 64'(NWORDS));
      chk("frameA_err",    64'(err_sof),  64'(0));
      chk("frameA_we_idle", 64'(fb_we),   64'(0));

      // Non-sof pixels while idle are swallowed.
      wsave = n_writes;
      for (int i = 0; i < 20; i++) send_pix(1'b0, 2'($urandom_range(0, 3)));
      repeat (10) step();
      chk("idle_no_writes", 64'(n_writes), 64'(wsave));
      chk("idle_ready",     64'(pix_ready), 64'(1));

      // First word 3,0,...,0 and its write latency.
      send_pix(1'b1, 2'd3);
      for (int i = 1; i < 16; i++) send_pix(1'b0, 2'd0);
      chk("first_word_we_not_yet", 64'(fb_we), 64'(0));
      step();
      chk("first_word_we",   64'(fb_we),   64'(1));
      chk("first_word_addr", 64'(fb_addr), 64'(0));
      chk("first_word_data", 64'(fb_data), 64'h0000_0000_C000_0000);

      // Mid-line stall of 100 cycles while pixels keep being offered.
      p = 16;
      for (; p < 40; p++) send_pix(1'b0, 2'($urandom_range(0, 3)));
      stall    = 1;
      fb_ready = 1'b0;
      for (int c = 0; c < 100; c++) begin
         pix_valid = 1'b1;
         pix_sof   = 1'b0;
         pix_data  = 2'($urandom_range(0, 3));
         @(negedge clk);
         if (pix_ready) p++;
         step();
      end
      chk("stall_ready_low", 64'(pix_ready), 64'(0));
      chk("stall_we_high",   64'(fb_we),     64'(1));
      stall     = 0;
      pix_valid = 1'b0;
      for (; p < 500; p++) send_pix(1'b0, 2'($urandom_range(0, 3)));

      // Restart at pixel 500: partial word dropped, error latched.
      send_pix(1'b1, 2'($urandom_range(0, 3)));
      chk("err_sof_set",   64'(err_sof), 64'(1));
      chk("err_sof_model", 64'(err_sof), 64'(m_err));

      // Random valid/ready: rest of restarted frame plus two more frames.
      rnd_valid = 1;
      rnd_ready = 1;
      for (int i = 1; i < NPIX; i++) send_pix(1'b0, 2'($urandom_range(0, 3)));
      for (int f = 0; f < 2; f++) begin
         send_pix(1'b1, 2'($urandom_range(0, 3)));
         for (int i = 1; i < NPIX; i++) send_pix(1'b0, 2'($urandom_range(0, 3)));
      end
      wait_done(4);
      rnd_valid = 0;
      rnd_ready = 0;
      chk("frames_vs_model", 64'(n_done),  64'(m_frames));
      chk("err_sticky",      64'(err_sof), 64'(1));

      // Reset in the middle of a stalled frame.
      stall    = 1;
      fb_ready = 1'b0;
      send_pix(1'b1, 2'($urandom_range(0, 3)));
      for (int i = 1; i < 40; i++) send_pix(1'b0, 2'($urandom_range(0, 3)));
      step();
      chk("pre_reset_we", 64'(fb_we), 64'(1));
      wsave = n_writes;
      rst_n = 1'b0;
      #1;
      chk("midreset_we",        64'(fb_we),     64'(0));
      chk("midreset_pix_ready", 64'(pix_ready), 64'(1));
      chk("midreset_err_sof",   64'(err_sof),   64'(0));
      chk("midreset_addr",      64'(fb_addr),   64'(0));
      step();
      step();
      rst_n = 1'b1;
      stall = 0;
      repeat (50) step();
      chk("post_reset_no_writes", 64'(n_writes), 64'(wsave));
      chk("post_reset_we",        64'(fb_we),    64'(0));

      summary_and_finish();
   end

endmodule
`default_nettype wire
